if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined RV32I core: holds the program counter, drives the word address of the instruction memory (`imem`), and captures the returned instruction into the IF/ID pipeline register for decode. It applies hazard-unit stall/flush controls and branch/jump redirects from Execute. The output is the instruction, PC, PC+4 and valid bit presented to Decode.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- IMEM_AW, 6, instruction-memory word-address width (64 words)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall_f  in  1  hold PC (hazard unit)
- stall_d  in  1  hold IF/ID register
- flush_d  in  1  replace IF/ID contents with bubble
- pc_src_e  in  1  redirect PC to pc_target_e (taken branch/jump in Execute)
- pc_target_e  in  32  redirect target byte address
- imem_a  out  IMEM_AW  word address to imem, = pc_f[IMEM_AW+1:2]
- imem_rd  in  32  instruction from imem (combinational read of imem_a)
- pc_f  out  32  current fetch PC
- instr_d  out  32  instruction to Decode
- pc_d  out  32  PC of instr_d
- pc_plus4_d  out  32  pc_d + 4
- valid_d  out  1  instr_d is a real fetched instruction
- oor_d  out  1  instr_d came from a PC outside imem range
- fetch_cnt  out  32  count of valid instructions accepted into IF/ID

## Operation
- PC next-value priority (posedge clk): reset > pc_src_e > stall_f > sequential.
  - pc_src_e=1: pc_f <= {pc_target_e[31:2], 2'b00}; redirect wins over stall_f.
  - stall_f=1 (no redirect): pc_f holds.
  - else pc_f <= pc_f + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Out-of-range: in_range = (pc_f[31:IMEM_AW+2] == 0). If not in range, fetched word is replaced by NOP 32'h0000_0013 and oor flag is set; imem_a still equals low bits of PC.
- IF/ID register priority: reset > flush_d > stall_d > load.
  - flush_d=1: instr_d <= 32'h0000_0013, pc_d <= 0, pc_plus4_d <= 0, valid_d <= 0, oor_d <= 0.
  - stall_d=1: all IF/ID outputs hold.
  - load: instr_d <= in_range ? imem_rd : NOP; pc_d <= pc_f; pc_plus4_d <= pc_f + 4; valid_d <= 1; oor_d <= ~in_range.
- fetch_cnt increments by 1 (wraps modulo 2^32) on every cycle taking the load branch; held on flush, stall or reset-release cycle edge with no load.
- Reset (asynchronous, any time incl. mid-stall/redirect): pc_f = RESET_PC, instr_d = 32'h0000_0013, pc_d = 0, pc_plus4_d = 0, valid_d = 0, oor_d = 0, fetch_cnt = 0. imem_a = RESET_PC[IMEM_AW+1:2] immediately.

## Timing
- imem read is combinational: imem_rd reflects imem_a in the same cycle; this block adds no combinational path from imem_rd to any output except through the IF/ID flops.
- Fetch latency: instruction at PC p appears on instr_d one clock edge after pc_f = p (given no stall_d/flush_d).
- Redirect: pc_src_e sampled at edge N sets pc_f = target after edge N; target instruction on instr_d after edge N+1. Hazard unit asserts flush_d with pc_src_e in the same cycle; this block does not generate the flush itself.
- stall_f and stall_d are independent; when both asserted the pipeline front end freezes with no loss of the instruction in IF/ID.
- flush_d and stall_d together: flush wins (bubble inserted).
- Reset deassertion: first load on the first rising edge after reset falls, capturing instruction at RESET_PC.

## Test plan
- Reset then free-run, imem[0..2] = 00500093, 00A00113, 002081B3 -> pc_f 0,4,8,12; instr_d shows the three words on consecutive cycles with pc_d 0,4,8, pc_plus4_d 4,8,12, valid_d=1, fetch_cnt 1,2,3.
- stall_f=stall_d=1 for 2 cycles while instr_d=00A00113, pc_f=8 -> all outputs and fetch_cnt hold; release resumes with 002081B3.
- pc_src_e=1, pc_target_e=0x00000006, flush_d=1, with stall_f=1 same cycle -> pc_f=0x4, instr_d=00000013, valid_d=0; next cycle instr_d=imem[1], pc_d=4.
- Redirect to 0x00000100 (IMEM_AW=6) -> instr_d=00000013, oor_d=1, valid_d=1, pc_d=0x100; fetch_cnt increments.
- pc_f forced near 0xFFFF_FFFC via redirect -> next pc_f = 0, pc_plus4_d of that instruction = 0.
- Assert reset asynchronously mid-cycle during a stall -> outputs go to reset values immediately (before next edge), pc_f = RESET_PC, fetch_cnt = 0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, imem word addressing, and the IF/ID
// pipeline register presented to Decode, with stall/flush and Execute redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_f,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               pc_src_e,
  input  logic [31:0]        pc_target_e,
  output logic [IMEM_AW-1:0] imem_a,
  input  logic [31:0]        imem_rd,
  output logic [31:0]        pc_f,
  output logic [31:0]        instr_d,
  output logic [31:0]        pc_d,
  output logic [31:0]        pc_plus4_d,
  output logic               valid_d,
  output logic               oor_d,
  output logic [31:0]        fetch_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Control semantics: a redirect always moves the PC, even under stall_f.
  // On the IF/ID side flush_d beats stall_d, and stall_d holds every output.
  // fetch_cnt advances only on edges where IF/ID actually loads a fetch.

  logic [31:0] pc_plus4_f;
  logic [31:0] pc_next;
  logic        in_range;
  logic [31:0] fetch_word;

  assign pc_plus4_f = pc_f + 32'd4;
  assign in_range   = (pc_f[31:IMEM_AW+2] == '0);
  assign imem_a     = pc_f[IMEM_AW+1:2];
  assign fetch_word = in_range ? imem_rd : NOP;

  always_comb begin
    pc_next = pc_f;
    if (pc_src_e)
      pc_next = pc_target_e & 32'hFFFF_FFFC;
    else if (!stall_f)
      pc_next = pc_plus4_f;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc_f <= RESET_PC;
    else
      pc_f <= pc_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d    <= NOP;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
      oor_d      <= 1'b0;
      fetch_cnt  <= '0;
    end else if (flush_d) begin
      instr_d    <= NOP;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
      oor_d      <= 1'b0;
    end else if (!stall_d) begin
      instr_d    <= fetch_word;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
      valid_d    <= 1'b1;
      oor_d      <= ~in_range;
      fetch_cnt  <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random control traffic, compared
// each cycle against a behavioural model of the fetch stage.
module tb_if_stage;

  localparam int          AW       = 6;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam longint      IMEM_LIM = 4 * (64'd1 << AW);

  logic          clk;
  logic          rst;
  logic          stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0]   pc_target_e;
  logic [AW-1:0] imem_a;
  logic [31:0]   imem_rd;
  logic [31:0]   pc_f, instr_d, pc_d, pc_plus4_d, fetch_cnt;
  logic          valid_d, oor_d;

  logic [31:0]   imem [64];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_cnt;
  logic        m_valid, m_oor;

  if_stage #(.RESET_PC(RST_PC), .IMEM_AW(AW)) dut (
    .clk(clk), .reset(rst), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_a(imem_a), .imem_rd(imem_rd), .pc_f(pc_f), .instr_d(instr_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .oor_d(oor_d),
    .fetch_cnt(fetch_cnt)
  );

  assign imem_rd = imem[imem_a];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = NOP; m_pcd = 0; m_pc4d = 0;
    m_valid = 0; m_oor = 0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pc_f"},       pc_f,       m_pc);
    check_eq({tag, ".imem_a"},     {26'd0, imem_a}, (m_pc / 4) % 64);
    check_eq({tag, ".instr_d"},    instr_d,    m_instr);
    check_eq({tag, ".pc_d"},       pc_d,       m_pcd);
    check_eq({tag, ".pc_plus4_d"}, pc_plus4_d, m_pc4d);
    check_eq({tag, ".valid_d"},    {31'd0, valid_d}, {31'd0, m_valid});
    check_eq({tag, ".oor_d"},      {31'd0, oor_d},   {31'd0, m_oor});
    check_eq({tag, ".fetch_cnt"},  fetch_cnt,  m_cnt);
  endtask

  // Drive one cycle of controls, advance the model by one edge, check after it.
  task automatic step(input string tag, input logic sf, input logic sd, input logic fl,
                      input logic src, input logic [31:0] tgt);
    logic        in_rng;
    logic [31:0] word;
    stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = src; pc_target_e = tgt;
    in_rng = (longint'(m_pc) < IMEM_LIM);
    word   = in_rng ? imem[(m_pc / 4) % 64] : NOP;
    if (fl) begin
      m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_valid = 0; m_oor = 0;
    end else if (!sd) begin
      m_instr = word; m_pcd = m_pc; m_pc4d = m_pc + 4;
      m_valid = 1; m_oor = !in_rng; m_cnt = m_cnt + 1;
    end
    if (src)      m_pc = (tgt / 4) * 4;
    else if (!sf) m_pc = m_pc + 4;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    imem[0] = 32'h0050_0093;
    imem[1] = 32'h00A0_0113;
    imem[2] = 32'h0020_81B3;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // free run from reset
    step("run0", 0, 0, 0, 0, 0);
    check_eq("run0.first_instr", instr_d, 32'h0050_0093);
    step("run1", 0, 0, 0, 0, 0);
    check_eq("run1.second_instr", instr_d, 32'h00A0_0113);

    // full front-end freeze, then resume
    step("frz0", 1, 1, 0, 0, 0);
    step("frz1", 1, 1, 0, 0, 0);
    check_eq("frz.cnt_hold", fetch_cnt, 32'd2);
    step("resume", 0, 0, 0, 0, 0);
    check_eq("resume.instr", instr_d, 32'h0020_81B3);

    // redirect beats stall_f, misaligned target truncated
    step("redir6", 1, 0, 1, 1, 32'h0000_0006);
    check_eq("redir6.pc", pc_f, 32'h0000_0004);
    step("redir6.next", 0, 0, 0, 0, 0);
    check_eq("redir6.instr", instr_d, 32'h00A0_0113);

    // out-of-range fetch
    step("redir100", 0, 0, 1, 1, 32'h0000_0100);
    step("oor", 0, 0, 0, 0, 0);
    check_eq("oor.flag", {31'd0, oor_d}, 32'd1);

    // PC wrap at top of address space
    step("redir_top", 0, 0, 1, 1, 32'hFFFF_FFFC);
    step("wrap", 0, 0, 0, 0, 0);
    check_eq("wrap.pc_f", pc_f, 32'h0);
    check_eq("wrap.pc_plus4_d", pc_plus4_d, 32'h0);
    step("after_wrap", 0, 0, 0, 0, 0);

    // flush together with stall_d
    step("flush_stall", 0, 1, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic src;
      logic [31:0] tgt;
      src = ($urandom_range(0, 9) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h13F);
      step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           src ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0), src, tgt);
    end

    // asynchronous reset in the middle of a stall
    stall_f = 1; stall_d = 1; flush_d = 0; pc_src_e = 0;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst = 1'b0;
    step("post_rst0", 0, 0, 0, 0, 0);
    check_eq("post_rst0.instr", instr_d, 32'h0050_0093);
    step("post_rst1", 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
